// File: rtl/game_pkg.sv
// Shared definitions for the game session controller and its game cores.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package game_pkg;

    // Result digits a game core shows at the end of a round.
    localparam logic [3:0] DIGIT_RIGHT = 4'd10;
    localparam logic [3:0] DIGIT_WRONG = 4'd11;

    // disp_mode encodings towards the display driver.
    localparam logic [1:0] MODE_MENU  = 2'd0;
    localparam logic [1:0] MODE_PLAY  = 2'd1;
    localparam logic [1:0] MODE_SCORE = 2'd2;

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_SCORE = 2'd3
    } state_t;

    function automatic logic is_result(input logic [3:0] v);
        return (v == DIGIT_RIGHT) || (v == DIGIT_WRONG);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for four already-debounced button levels.
// Latency: rise is combinational from btn against the registered previous level.
// Backpressure: none; every rising edge yields exactly one cycle of rise.
// Ports: clk, rst_n (async active-low), btn[3:0] levels in, rise[3:0] pulses out.
module btn_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    output logic [3:0] rise
);

    logic [3:0] btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 4'd0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller: game menu, core enable/mux, round and score tally, score display.
// Latency: all outputs registered; one cycle from button edge or core digit to output.
// Backpressure: none; button edges are consumed or forwarded the cycle they occur.
// Ports: clk, reset (async active-low), btn[3:0] levels, game_value[4*NUM_GAMES-1:0] core digits,
//        game_run one-hot core enable, game_btn forwarded edges, disp_value/disp_mode display, score.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int NUM_GAMES    = 4,
    parameter int ROUNDS       = 8,
    parameter int SCORE_CYCLES = 10_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             btn,
    input  logic [4*NUM_GAMES-1:0] game_value,
    output logic [NUM_GAMES-1:0]   game_run,
    output logic [3:0]             game_btn,
    output logic [3:0]             disp_value,
    output logic [1:0]             disp_mode,
    output logic [3:0]             score
);

    localparam int         CW        = (SCORE_CYCLES > 1) ? $clog2(SCORE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCORE_CYCLES - 1);
    localparam logic [1:0] SEL_MAX   = 2'(NUM_GAMES - 1);
    localparam logic [3:0] ROUND_MAX = 4'(ROUNDS);

    state_t           state, state_nxt;
    logic [1:0]       sel, sel_nxt;
    logic [3:0]       round, round_nxt;
    logic [3:0]       score_nxt;
    logic [3:0]       pv;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [3:0]       rise;
    logic [3:0]       cur;
    logic             sel_ok;
    logic             entry_right, entry_wrong;

    logic [NUM_GAMES-1:0] run_nxt;
    logic [3:0]           gbtn_nxt;
    logic [3:0]           dval_nxt;
    logic [1:0]           dmode_nxt;

    btn_edge u_btn_edge (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn),
        .rise  (rise)
    );

    // With fewer than four cores a corrupted sel can point past the last core.
    generate
        if (NUM_GAMES < 4) begin : g_sel_chk
            assign sel_ok = (sel <= SEL_MAX);
        end else begin : g_sel_full
            assign sel_ok = 1'b1;
        end
    endgenerate

    assign cur = sel_ok ? game_value[{sel, 2'b00} +: 4] : 4'd0;

    // Only a change into a result digit counts, so a held result scores once
    // while a direct RIGHT<->WRONG swap is a fresh result.
    assign entry_right = (cur == DIGIT_RIGHT) && (pv != DIGIT_RIGHT);
    assign entry_wrong = (cur == DIGIT_WRONG) && (pv != DIGIT_WRONG);

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        round_nxt = round;
        score_nxt = score;
        cnt_nxt   = '0;
        gbtn_nxt  = 4'd0;

        if (!sel_ok) begin
            state_nxt = ST_MENU;
            sel_nxt   = 2'd0;
        end else begin
            case (state)
                ST_MENU: begin
                    if (rise[3]) begin
                        state_nxt = ST_ARMED;
                        round_nxt = 4'd0;
                        score_nxt = 4'd0;
                    end else if (rise[1] && !rise[0]) begin
                        sel_nxt = (sel == SEL_MAX) ? 2'd0 : sel + 2'd1;
                    end else if (rise[0] && !rise[1]) begin
                        sel_nxt = (sel == 2'd0) ? SEL_MAX : sel - 2'd1;
                    end
                end
                ST_ARMED: begin
                    // Wait for full release so the start press never reaches the core.
                    if (btn == 4'd0) begin
                        state_nxt = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    gbtn_nxt = rise;
                    if (rise[2] && btn[3]) begin
                        state_nxt = ST_MENU;
                        round_nxt = 4'd0;
                        score_nxt = 4'd0;
                    end else begin
                        if (entry_right || entry_wrong) begin
                            if (round != ROUND_MAX) round_nxt = round + 4'd1;
                        end
                        if (entry_right && (score != ROUND_MAX)) begin
                            score_nxt = score + 4'd1;
                        end
                        // Leave only once the core has stopped showing its last result.
                        if ((round == ROUND_MAX) && !is_result(cur)) begin
                            state_nxt = ST_SCORE;
                        end
                    end
                end
                ST_SCORE: begin
                    if ((rise != 4'd0) || (cnt == CNT_LAST)) begin
                        state_nxt = ST_MENU;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_MENU;
                    sel_nxt   = 2'd0;
                end
            endcase
        end

        // Outputs are derived from the next state so they register together with it.
        run_nxt   = '0;
        dval_nxt  = {2'b00, sel_nxt} + 4'd1;
        dmode_nxt = MODE_MENU;
        case (state_nxt)
            ST_PLAY: begin
                run_nxt   = NUM_GAMES'(1) << sel_nxt;
                dval_nxt  = cur;
                dmode_nxt = MODE_PLAY;
            end
            ST_SCORE: begin
                dval_nxt  = score_nxt;
                dmode_nxt = MODE_SCORE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_MENU;
            sel        <= 2'd0;
            round      <= 4'd0;
            score      <= 4'd0;
            pv         <= 4'd0;
            cnt        <= '0;
            game_run   <= '0;
            game_btn   <= 4'd0;
            disp_value <= 4'd0;
            disp_mode  <= MODE_MENU;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            round      <= round_nxt;
            score      <= score_nxt;
            pv         <= cur;
            cnt        <= cnt_nxt;
            game_run   <= run_nxt;
            game_btn   <= gbtn_nxt;
            disp_value <= dval_nxt;
            disp_mode  <= dmode_nxt;
        end
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: menu, start, tally, score exit, abort, async reset.
// Latency: inputs driven #1 after posedge, outputs checked at the same point.
// Backpressure: n/a.
module tb_game_session_ctrl;

    localparam int NG = 4;
    localparam int RN = 3;
    localparam int SC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      btn;
    logic [3:0]      gv [4];
    logic [4*NG-1:0] game_value;
    logic [NG-1:0]   game_run;
    logic [3:0]      game_btn;
    logic [3:0]      disp_value;
    logic [1:0]      disp_mode;
    logic [3:0]      score;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign game_value = {gv[3], gv[2], gv[1], gv[0]};

    game_session_ctrl #(
        .NUM_GAMES    (NG),
        .ROUNDS       (RN),
        .SCORE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .game_value (game_value),
        .game_run   (game_run),
        .game_btn   (game_btn),
        .disp_value (disp_value),
        .disp_mode  (disp_mode),
        .score      (score)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick();
        btn = 4'd0;
        tick();
    endtask

    task automatic start_session();
        btn = 4'b1000;
        tick();
        btn = 4'd0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn   = 4'd0;
        for (int i = 0; i < 4; i++) gv[i] = 4'd0;
        gv[1] = 4'd7;
        gv[3] = 4'd7;
        tick();
        tick();
        vec++; if (game_run !== 4'd0) begin $display("FAIL reset_game_run got %b want 0000", game_run); errs++; end
        vec++; if (game_btn !== 4'd0) begin $display("FAIL reset_game_btn got %b want 0000", game_btn); errs++; end
        vec++; if (disp_value !== 4'd0) begin $display("FAIL reset_disp_value got %0d want 0", disp_value); errs++; end
        vec++; if (disp_mode !== 2'd0) begin $display("FAIL reset_disp_mode got %0d want 0", disp_mode); errs++; end
        vec++; if (score !== 4'd0) begin $display("FAIL reset_score got %0d want 0", score); errs++; end
        reset = 1'b1;
        tick();
        vec++; if (disp_value !== 4'd1) begin $display("FAIL reset_release_disp got %0d want 1", disp_value); errs++; end
        vec++; if (disp_mode !== 2'd0) begin $display("FAIL reset_release_mode got %0d want 0", disp_mode); errs++; end
    endtask

    task automatic test_menu();
        int exp_up [5] = '{2, 3, 4, 1, 2};
        for (int i = 0; i < 5; i++) begin
            press(1);
            vec++;
            if (disp_value !== 4'(exp_up[i])) begin
                $display("FAIL menu_up[%0d] got %0d want %0d", i, disp_value, exp_up[i]); errs++;
            end
        end
        press(0);
        vec++; if (disp_value !== 4'd1) begin $display("FAIL menu_down got %0d want 1", disp_value); errs++; end
        press(0);
        vec++; if (disp_value !== 4'd4) begin $display("FAIL menu_down_wrap got %0d want 4", disp_value); errs++; end
        btn = 4'b0011;
        tick();
        vec++; if (disp_value !== 4'd4) begin $display("FAIL menu_both got %0d want 4", disp_value); errs++; end
        btn = 4'd0;
        tick();
        press(1);
        vec++; if (disp_value !== 4'd1) begin $display("FAIL menu_up_wrap got %0d want 1", disp_value); errs++; end
    endtask

    task automatic test_start();
        btn = 4'b1000;
        tick();
        for (int i = 0; i < 19; i++) begin
            vec++;
            if (game_run !== 4'd0 || game_btn !== 4'd0) begin
                $display("FAIL start_held[%0d] got run=%b btn=%b want 0000/0000", i, game_run, game_btn); errs++;
            end
            tick();
        end
        btn = 4'd0;
        tick();
        vec++; if (game_run !== 4'b0001) begin $display("FAIL start_run got %b want 0001", game_run); errs++; end
        vec++; if (game_btn !== 4'd0) begin $display("FAIL start_no_btn got %b want 0000", game_btn); errs++; end
        vec++; if (disp_mode !== 2'd1) begin $display("FAIL start_mode got %0d want 1", disp_mode); errs++; end
        btn = 4'b0001;
        tick();
        vec++; if (game_btn !== 4'b0001) begin $display("FAIL fwd_pulse got %b want 0001", game_btn); errs++; end
        tick();
        vec++; if (game_btn !== 4'd0) begin $display("FAIL fwd_one_cycle got %b want 0000", game_btn); errs++; end
        btn = 4'd0;
        tick();
    endtask

    task automatic test_tally();
        gv[0] = 4'd10;
        tick();
        vec++; if (score !== 4'd1) begin $display("FAIL tally_r1 got %0d want 1", score); errs++; end
        vec++; if (disp_value !== 4'd10) begin $display("FAIL tally_disp got %0d want 10", disp_value); errs++; end
        repeat (4) tick();
        vec++; if (score !== 4'd1) begin $display("FAIL tally_hold got %0d want 1", score); errs++; end
        gv[0] = 4'd0;  tick();
        gv[0] = 4'd11; tick();
        vec++; if (score !== 4'd1) begin $display("FAIL tally_wrong got %0d want 1", score); errs++; end
        gv[0] = 4'd0;  tick();
        vec++; if (disp_mode !== 2'd1) begin $display("FAIL tally_round2_mode got %0d want 1", disp_mode); errs++; end
        gv[0] = 4'd10; tick();
        vec++; if (score !== 4'd2) begin $display("FAIL tally_r3 got %0d want 2", score); errs++; end
        repeat (4) tick();
        vec++; if (disp_mode !== 2'd1) begin $display("FAIL tally_wait_clear got %0d want 1", disp_mode); errs++; end
        gv[0] = 4'd0;
        tick();
        vec++; if (disp_mode !== 2'd2) begin $display("FAIL tally_score_mode got %0d want 2", disp_mode); errs++; end
        vec++; if (disp_value !== 4'd2) begin $display("FAIL tally_score_disp got %0d want 2", disp_value); errs++; end
        vec++; if (game_run !== 4'd0) begin $display("FAIL tally_score_run got %b want 0000", game_run); errs++; end
    endtask

    task automatic test_score_timeout();
        for (int k = 1; k < SC; k++) begin
            tick();
            vec++;
            if (disp_mode !== 2'd2) begin $display("FAIL timeout_hold[%0d] got %0d want 2", k, disp_mode); errs++; end
        end
        tick();
        vec++; if (disp_mode !== 2'd0) begin $display("FAIL timeout_exit got %0d want 0", disp_mode); errs++; end
        vec++; if (disp_value !== 4'd1) begin $display("FAIL timeout_menu_disp got %0d want 1", disp_value); errs++; end
    endtask

    task automatic test_direct_change();
        btn = 4'b1000;
        tick();
        vec++; if (score !== 4'd0) begin $display("FAIL start_clears_score got %0d want 0", score); errs++; end
        btn = 4'd0;
        tick();
        gv[0] = 4'd10; tick();
        gv[0] = 4'd11; tick();
        vec++; if (score !== 4'd1) begin $display("FAIL swap_to_wrong got %0d want 1", score); errs++; end
        gv[0] = 4'd10; tick();
        vec++; if (score !== 4'd2) begin $display("FAIL swap_to_right got %0d want 2", score); errs++; end
        tick();
        vec++; if (disp_mode !== 2'd1) begin $display("FAIL swap_still_play got %0d want 1", disp_mode); errs++; end
        gv[0] = 4'd0;
        tick();
        vec++; if (disp_mode !== 2'd2 || disp_value !== 4'd2) begin
            $display("FAIL swap_score got mode=%0d disp=%0d want 2/2", disp_mode, disp_value); errs++;
        end
    endtask

    task automatic test_score_button();
        tick();
        tick();
        vec++; if (disp_mode !== 2'd2) begin $display("FAIL scorebtn_hold got %0d want 2", disp_mode); errs++; end
        btn = 4'b0001;
        tick();
        vec++; if (disp_mode !== 2'd0) begin $display("FAIL scorebtn_exit got %0d want 0", disp_mode); errs++; end
        btn = 4'd0;
        tick();
        vec++; if (disp_value !== 4'd1) begin $display("FAIL scorebtn_sel got %0d want 1", disp_value); errs++; end
    endtask

    task automatic test_abort();
        press(1);
        press(1);
        vec++; if (disp_value !== 4'd3) begin $display("FAIL abort_sel got %0d want 3", disp_value); errs++; end
        start_session();
        vec++; if (game_run !== 4'b0100) begin $display("FAIL abort_run got %b want 0100", game_run); errs++; end
        gv[2] = 4'd6;
        tick();
        vec++; if (disp_value !== 4'd6) begin $display("FAIL core_mux got %0d want 6", disp_value); errs++; end
        gv[2] = 4'd10; tick();
        gv[2] = 4'd0;  tick();
        vec++; if (score !== 4'd1) begin $display("FAIL abort_pre_score got %0d want 1", score); errs++; end
        btn = 4'b1000;
        tick();
        vec++; if (disp_mode !== 2'd1 || game_btn !== 4'b1000) begin
            $display("FAIL abort_hold4 got mode=%0d btn=%b want 1/1000", disp_mode, game_btn); errs++;
        end
        btn = 4'b1100;
        tick();
        vec++; if (disp_mode !== 2'd0) begin $display("FAIL abort_mode got %0d want 0", disp_mode); errs++; end
        vec++; if (game_run !== 4'd0) begin $display("FAIL abort_run_off got %b want 0000", game_run); errs++; end
        vec++; if (game_btn !== 4'b0100) begin $display("FAIL abort_fwd got %b want 0100", game_btn); errs++; end
        vec++; if (disp_value !== 4'd3) begin $display("FAIL abort_sel_kept got %0d want 3", disp_value); errs++; end
        btn = 4'd0;
        tick();
        start_session();
        vec++; if (game_run !== 4'b0100 || score !== 4'd0) begin
            $display("FAIL abort_restart got run=%b score=%0d want 0100/0", game_run, score); errs++;
        end
    endtask

    task automatic test_reset_mid();
        gv[2] = 4'd10;
        tick();
        vec++; if (score !== 4'd1 || disp_value !== 4'd10) begin
            $display("FAIL mid_pre got score=%0d disp=%0d want 1/10", score, disp_value); errs++;
        end
        #3;
        reset = 1'b0;
        #1;
        vec++; if (game_run !== 4'd0) begin $display("FAIL mid_run got %b want 0000", game_run); errs++; end
        vec++; if (disp_value !== 4'd0 || disp_mode !== 2'd0) begin
            $display("FAIL mid_disp got %0d/%0d want 0/0", disp_value, disp_mode); errs++;
        end
        vec++; if (score !== 4'd0 || game_btn !== 4'd0) begin
            $display("FAIL mid_score_btn got %0d/%b want 0/0000", score, game_btn); errs++;
        end
        gv[2] = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        vec++; if (disp_value !== 4'd1 || disp_mode !== 2'd0) begin
            $display("FAIL mid_release got disp=%0d mode=%0d want 1/0", disp_value, disp_mode); errs++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_menu();
        test_start();
        test_tally();
        test_score_timeout();
        test_direct_change();
        test_score_button();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
